// File: rtl/wt_16.sv
// wt_16: 16x16 unsigned Wallace-tree multiplier with a registered 32-bit product.
module wt_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [31:0] P
);
  logic [31:0] r [18];
  logic [31:0] t [18];
  logic [31:0] p_next;
  int n, m;
  always_comb begin
    for (int i = 0; i < 18; i++) r[i] = '0;
    for (int i = 0; i < 16; i++) r[i] = {16'b0, A & {16{B[i]}}} << i;
    n = 16;
    // 3:2 compression of row triples: 16->11->8->6->4->3->2
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < 18; i++) t[i] = '0;
      m = 0;
      for (int g = 0; g < 6; g++) begin
        if (3 * g + 2 < n) begin
          t[m]     = r[3*g] ^ r[3*g+1] ^ r[3*g+2];
          t[m+1]   = ((r[3*g] & r[3*g+1]) | (r[3*g] & r[3*g+2]) | (r[3*g+1] & r[3*g+2])) << 1;
          m        = m + 2;
        end else if (3 * g + 1 < n) begin
          t[m]     = r[3*g] ^ r[3*g+1];
          t[m+1]   = (r[3*g] & r[3*g+1]) << 1;
          m        = m + 2;
        end else if (3 * g < n) begin
          t[m]     = r[3*g];
          m        = m + 1;
        end
      end
      for (int i = 0; i < 18; i++) r[i] = t[i];
      n = m;
    end
    p_next = r[0] + r[1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) P <= '0;
    else P <= p_next;
endmodule

// File: tb/tb_wt_16.sv
// tb_wt_16: scoreboard bench for the wt_16 multiplier.
module tb_wt_16;
  logic clk = 0, rst_n = 0;
  logic [15:0] A = '0, B = '0;
  logic [31:0] P;
  logic [31:0] q [$];
  int n_chk = 0, n_fail = 0;
  integer seed = 7;
  integer v, w;
  logic [31:0] hold;

  wt_16 dut (.clk(clk), .rst_n(rst_n), .A(A), .B(B), .P(P));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    A = a;
    B = b;
    q.push_back({16'b0, a} * {16'b0, b});
    @(posedge clk);
    #1 check(tag, P, q.pop_front());
  endtask

  initial begin
    A = 16'hFFFF;
    B = 16'hFFFF;
    #1 check("reset_async", P, 32'h0);
    repeat (3) begin
      @(posedge clk);
      #1 check("reset_hold", P, 32'h0);
    end
    @(negedge clk) rst_n = 1;
    step("ffff_sq", 16'hFFFF, 16'hFFFF);
    step("zero", 16'h0000, 16'hABCD);
    step("one", 16'h0001, 16'hABCD);
    step("msb", 16'h8000, 16'h0002);
    step("7ffe_sq", 16'h7FFE, 16'h7FFE);
    step("unsigned", 16'hFFFF, 16'h0003);
    check("unsigned_const", P, 32'h0002_FFFD);
    #2 A = 16'h1234;
    B = 16'h5678;
    #1 check("hold_between", P, 32'h0002_FFFD);
    for (int i = 0; i < 500; i++) begin
      v = $random(seed) % 32767;
      w = $random(seed) % 32767;
      step("random", v[15:0], w[15:0]);
    end
    step("pre_reset", 16'h1234, 16'h5678);
    #2 rst_n = 0;
    #1 check("async_mid", P, 32'h0);
    @(posedge clk);
    #1 check("mid_hold", P, 32'h0);
    @(negedge clk) rst_n = 1;
    step("after_reset", 16'hC001, 16'h00FF);
    check("after_reset_const", P, 32'h00BF_40FF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
